// File: rtl/generation_sequencer_pkg.sv
// Shared types and defaults for the Game-of-Life generation sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package generation_sequencer_pkg;

    localparam int COUNT_W_DEF    = 8;
    localparam int TICK_DIV_SIM   = 4;
    localparam int TICK_DIV_BOARD = 10_000_000;
    localparam int TIMEOUT_DEF    = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_START     = 3'd2,
        ST_BUSY      = 3'd3,
        ST_UPDATE    = 3'd4
    } state_t;

    // A generation is in flight from its start pulse through the count update.
    function automatic logic in_flight(input state_t s);
        return (s == ST_START) || (s == ST_BUSY) || (s == ST_UPDATE);
    endfunction

endpackage

// File: rtl/generation_sequencer_if.sv
// Control, engine handshake and display-count signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all handshakes are single-cycle pulses.
interface generation_sequencer_if
    import generation_sequencer_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
);
    logic               run_sw;
    logic               step_btn;
    logic               clear_btn;
    logic               gen_start;
    logic               gen_done;
    logic               busy;
    logic [COUNT_W-1:0] iter_count;
    logic               count_valid;
    logic               err;

    modport master (
        input  run_sw, step_btn, clear_btn, gen_done,
        output gen_start, busy, iter_count, count_valid, err
    );

    modport slave (
        output run_sw, step_btn, clear_btn, gen_done,
        input  gen_start, busy, iter_count, count_valid, err
    );
endinterface

// File: rtl/generation_sequencer_tick_prescaler.sv
// Enable-based modulo-DIV counter with a registered terminal-count pulse.
// Latency: tc rises one cycle after the count reaches DIV-1.
// Backpressure: none; counting simply holds while en is low.
module generation_sequencer_tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc    <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tc    <= 1'b0;
        end else if (en && (cnt_q == W'(DIV - 1))) begin
            cnt_q <= '0;
            tc    <= 1'b1;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
            tc    <= 1'b0;
        end else begin
            tc    <= 1'b0;
        end
    end
endmodule

// File: rtl/generation_sequencer.sv
// Decides when the grid engine runs (run/pause/step) and owns the iteration count.
// Latency: step -> gen_start +1 cycle; gen_done -> iter_count/count_valid +2 cycles.
// Backpressure: step ignored while a generation is in flight; engine must answer within TIMEOUT.
module generation_sequencer
    import generation_sequencer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_BOARD,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int COUNT_W  = COUNT_W_DEF,
    parameter bit WRAP     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    generation_sequencer_if.master bus
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic               tick;
    logic [TO_W-1:0]    to_cnt_q;
    logic               timeout_hit;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_next;
    logic               cnt_vld_q;
    logic               err_q;

    generation_sequencer_tick_prescaler #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_WAIT_TICK),
        .clr   (state_q != ST_WAIT_TICK),
        .tc    (tick)
    );

    assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign cnt_next    = (!WRAP && (cnt_q == '1)) ? cnt_q : cnt_q + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.step_btn)    state_d = ST_START;
                else if (bus.run_sw) state_d = ST_WAIT_TICK;
            end
            // Pausing drops back to IDLE, which clears the partial tick period.
            ST_WAIT_TICK: begin
                if (!bus.run_sw) state_d = ST_IDLE;
                else if (tick)   state_d = ST_START;
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.gen_done)     state_d = ST_UPDATE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_UPDATE: state_d = bus.run_sw ? ST_WAIT_TICK : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counts from the start cycle so the wait window ends TIMEOUT cycles after gen_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         to_cnt_q <= '0;
        else if (state_q == ST_START || state_q == ST_BUSY) to_cnt_q <= to_cnt_q + TO_W'(1);
        else                                                to_cnt_q <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cnt_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_vld_q <= bus.clear_btn || (state_q == ST_UPDATE);
            if (bus.clear_btn)             cnt_q <= '0;
            else if (state_q == ST_UPDATE) cnt_q <= cnt_next;
            if (state_q == ST_BUSY && !bus.gen_done && timeout_hit) err_q <= 1'b1;
            else if (bus.clear_btn)                                 err_q <= 1'b0;
        end
    end

    assign bus.gen_start   = (state_q == ST_START);
    assign bus.busy        = in_flight(state_q);
    assign bus.iter_count  = cnt_q;
    assign bus.count_valid = cnt_vld_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_generation_sequencer.sv
// Directed bench for generation_sequencer: wrapping and saturating instances side by side.
// Engine model answers gen_done three cycles after gen_start unless disabled.
// Backpressure: n/a.
module tb_generation_sequencer;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic engine_en = 1'b1;
    logic [2:0] sr_a, sr_b;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    generation_sequencer_if #(.COUNT_W(CW)) ifa ();
    generation_sequencer_if #(.COUNT_W(CW)) ifb ();

    generation_sequencer #(.TICK_DIV(4), .TIMEOUT(16), .COUNT_W(CW), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    generation_sequencer #(.TICK_DIV(4), .TIMEOUT(16), .COUNT_W(CW), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_a <= '0;
            sr_b <= '0;
        end else begin
            sr_a <= {sr_a[1:0], ifa.gen_start & engine_en};
            sr_b <= {sr_b[1:0], ifb.gen_start & engine_en};
        end
    end
    assign ifa.gen_done = sr_a[2];
    assign ifb.gen_done = sr_b[2];

    typedef struct {
        logic run_sw, step_btn, clear_btn;
        logic gen_start, busy, count_valid;
        int   iter_count;
        logic err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic c);
        ifa.run_sw = r; ifa.step_btn = s; ifa.clear_btn = c;
        ifb.run_sw = r; ifb.step_btn = s; ifb.clear_btn = c;
    endtask

    task automatic do_step(output bit timed_out);
        int waited;
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        waited = 0;
        while (!ifa.count_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        timed_out = (waited >= 20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gs_seen, cv_seen, step_to;
        bit to;

        //         run step clr   gs busy cv  cnt err
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};

        // Reset state
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_gen_start", ifa.gen_start, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_count", ifa.iter_count, 0);
        chk("rst_count_valid", ifa.count_valid, 0);
        chk("rst_err", ifa.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-step, clear in IDLE, step priority over run
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].run_sw, vecs[i].step_btn, vecs[i].clear_btn);
            @(negedge clk);
            chk($sformatf("vec%0d_gen_start", i), ifa.gen_start, vecs[i].gen_start);
            chk($sformatf("vec%0d_busy", i), ifa.busy, vecs[i].busy);
            chk($sformatf("vec%0d_count_valid", i), ifa.count_valid, vecs[i].count_valid);
            chk($sformatf("vec%0d_iter_count", i), ifa.iter_count, vecs[i].iter_count);
            chk($sformatf("vec%0d_err", i), ifa.err, vecs[i].err);
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Free-run: first start 6 cycles after run_sw, then every 10; pause in WAIT_TICK
        drive(1'b1, 1'b0, 1'b0);
        gs_seen = 0;
        cv_seen = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (ifa.gen_start) begin
                chk("run_gen_start_cycle", c, 6 + 10 * gs_seen);
                gs_seen++;
            end
            if (ifa.count_valid) cv_seen++;
            if (c == 33) drive(1'b0, 1'b0, 1'b0);
        end
        chk("run_gen_start_total", gs_seen, 3);
        chk("run_count_valid_total", cv_seen, 3);
        chk("run_final_count", ifa.iter_count, 4);
        chk("run_final_busy", ifa.busy, 0);

        // Clear back to zero
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk("clear_count_wrap", ifa.iter_count, 0);
        chk("clear_count_sat", ifb.iter_count, 0);
        chk("clear_count_valid", ifa.count_valid, 1);

        // Wrap vs saturate
        step_to = 0;
        for (int i = 0; i < 255; i++) begin
            do_step(to);
            if (to) step_to++;
        end
        chk("preload_step_timeouts", step_to, 0);
        chk("preload_count_wrap", ifa.iter_count, 255);
        chk("preload_count_sat", ifb.iter_count, 255);
        do_step(to);
        chk("wrap_step_timeout", int'(to), 0);
        chk("wrap_count", ifa.iter_count, 0);
        chk("wrap_count_valid", ifa.count_valid, 1);
        chk("sat_count", ifb.iter_count, 255);
        chk("sat_count_valid", ifb.count_valid, 1);
        @(negedge clk);

        // Timeout: engine silent, err 16 cycles after gen_start
        engine_en = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk("to_gen_start", ifa.gen_start, 1);
        repeat (15) @(negedge clk);
        chk("to_err_before", ifa.err, 0);
        chk("to_busy_before", ifa.busy, 1);
        @(negedge clk);
        chk("to_err", ifa.err, 1);
        chk("to_busy_after", ifa.busy, 0);
        chk("to_count_wrap", ifa.iter_count, 0);
        chk("to_count_sat", ifb.iter_count, 255);
        chk("to_count_valid", ifa.count_valid, 0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", ifa.err, 1);
        chk("to_gen_start_none", ifa.gen_start, 0);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk("to_clear_err", ifa.err, 0);
        chk("to_clear_err_sat", ifb.err, 0);
        chk("to_clear_count_sat", ifb.iter_count, 0);
        chk("to_clear_count_valid", ifb.count_valid, 1);
        engine_en = 1'b1;
        @(negedge clk);

        // Clear in UPDATE beats the increment
        do_step(to);
        chk("cvi_prestep_count", ifa.iter_count, 1);
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("cvi_update_busy", ifa.busy, 1);
        chk("cvi_update_count", ifa.iter_count, 1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk("cvi_count", ifa.iter_count, 0);
        chk("cvi_count_valid", ifa.count_valid, 1);
        chk("cvi_busy", ifa.busy, 0);
        @(negedge clk);
        chk("cvi_count_hold", ifa.iter_count, 0);
        chk("cvi_count_valid_drop", ifa.count_valid, 0);

        // Reset in the middle of BUSY
        do_step(to);
        chk("rmb_prestep_count", ifa.iter_count, 1);
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rmb_busy_before", ifa.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rmb_gen_start", ifa.gen_start, 0);
        chk("rmb_busy", ifa.busy, 0);
        chk("rmb_count", ifa.iter_count, 0);
        chk("rmb_count_valid", ifa.count_valid, 0);
        chk("rmb_err", ifa.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        gs_seen = 0;
        cv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifa.gen_start) gs_seen++;
            if (ifa.count_valid) cv_seen++;
        end
        chk("rmb_idle_gen_start", gs_seen, 0);
        chk("rmb_idle_count_valid", cv_seen, 0);
        chk("rmb_idle_busy", ifa.busy, 0);
        chk("rmb_idle_count", ifa.iter_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
